// File: rtl/uart_frame_rx.sv
//==============================================================================
// Module      : uart_frame_rx
// Description : UART receiver producing the 8-bit switch-addressed information
//               frame with mid-bit sampling, false-start reject and framing
//               check. Optional even parity via macro UART_FRAME_RX_PARITY_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module uart_frame_rx #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int DATA_BITS    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] informationBits,
    output logic       frameValid,
    output logic       framingError,
    output logic       parityError,
    output logic       busy
);

    localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] clk_cnt, clk_cnt_nxt;
    logic [2:0]       bit_cnt, bit_cnt_nxt;
    logic [7:0]       shift_reg, shift_nxt;
    logic [7:0]       info_nxt;
    logic             valid_nxt;
    logic             ferr_nxt;
    logic             rx_meta;
    logic             rx_s;
    logic             bit_done;

`ifdef UART_FRAME_RX_PARITY_EN
    logic par_bit, par_nxt;
    logic perr_nxt;
    logic par_bad;
    assign par_bad = ^{shift_reg, par_bit};
`endif

    // Synchronizer resets to idle-high so a reset never looks like a start bit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    assign bit_done = (clk_cnt == BIT_LAST);
    assign busy     = (state != IDLE);

    always_comb begin
        state_nxt   = state;
        clk_cnt_nxt = clk_cnt;
        bit_cnt_nxt = bit_cnt;
        shift_nxt   = shift_reg;
        info_nxt    = informationBits;
        valid_nxt   = 1'b0;
        ferr_nxt    = 1'b0;
`ifdef UART_FRAME_RX_PARITY_EN
        par_nxt     = par_bit;
        perr_nxt    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_nxt   = START;
                    clk_cnt_nxt = '0;
                end
            end
            START: begin
                if (clk_cnt == HALF_LAST) begin
                    clk_cnt_nxt = '0;
                    bit_cnt_nxt = '0;
                    state_nxt   = rx_s ? IDLE : DATA;
                end else begin
                    clk_cnt_nxt = clk_cnt + 1'b1;
                end
            end
            DATA: begin
                if (bit_done) begin
                    clk_cnt_nxt = '0;
                    shift_nxt   = {rx_s, shift_reg[7:1]};
                    bit_cnt_nxt = bit_cnt + 3'd1;
                    if (bit_cnt == LAST_BIT) begin
`ifdef UART_FRAME_RX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end
                end else begin
                    clk_cnt_nxt = clk_cnt + 1'b1;
                end
            end
`ifdef UART_FRAME_RX_PARITY_EN
            PARITY: begin
                if (bit_done) begin
                    clk_cnt_nxt = '0;
                    par_nxt     = rx_s;
                    state_nxt   = STOP;
                end else begin
                    clk_cnt_nxt = clk_cnt + 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_done) begin
                    clk_cnt_nxt = '0;
                    if (!rx_s) begin
                        ferr_nxt  = 1'b1;
                        state_nxt = WAIT_HIGH;
`ifdef UART_FRAME_RX_PARITY_EN
                    end else if (par_bad) begin
                        perr_nxt  = 1'b1;
                        state_nxt = IDLE;
`endif
                    end else begin
                        info_nxt  = shift_reg;
                        valid_nxt = 1'b1;
                        state_nxt = IDLE;
                    end
                end else begin
                    clk_cnt_nxt = clk_cnt + 1'b1;
                end
            end
            WAIT_HIGH: begin
                // A held-low line must not be mistaken for a fresh start bit
                if (rx_s) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            clk_cnt         <= '0;
            bit_cnt         <= '0;
            shift_reg       <= '0;
            informationBits <= 8'h00;
            frameValid      <= 1'b0;
            framingError    <= 1'b0;
        end else begin
            state           <= state_nxt;
            clk_cnt         <= clk_cnt_nxt;
            bit_cnt         <= bit_cnt_nxt;
            shift_reg       <= shift_nxt;
            informationBits <= info_nxt;
            frameValid      <= valid_nxt;
            framingError    <= ferr_nxt;
        end
    end

`ifdef UART_FRAME_RX_PARITY_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            par_bit     <= 1'b0;
            parityError <= 1'b0;
        end else begin
            par_bit     <= par_nxt;
            parityError <= perr_nxt;
        end
    end
`else
    assign parityError = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_frame_rx.sv
// Randomized self-checking bench for uart_frame_rx with an event-queue model of
// the expected strobes, their arrival cycle and the last good frame.
`default_nettype none

module tb_uart_frame_rx;

    localparam int CPB = 16;
`ifdef UART_FRAME_RX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif
    // Strobe arrives 2 sync cycles + 1 detect cycle + half a bit + the
    // remaining data/parity/stop bit times after the start edge.
    localparam int LAT = 3 + CPB / 2 + CPB * (8 + PBITS + 1);

    localparam int K_VALID = 0;
    localparam int K_FERR  = 1;
    localparam int K_PERR  = 2;

    logic       clk;
    logic       reset;
    logic       rx;
    logic [7:0] informationBits;
    logic       frameValid;
    logic       framingError;
    logic       parityError;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int         kind;
        logic [7:0] data;
        int         due;
    } ev_t;

    ev_t        q[$];
    logic [7:0] exp_info = 8'h00;

    uart_frame_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .rx             (rx),
        .informationBits(informationBits),
        .frameValid     (frameValid),
        .framingError   (framingError),
        .parityError    (parityError),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare process: every cycle, strobes against the event queue and
    // informationBits against the last good frame in the model.
    always @(negedge clk) begin
        if (!reset) begin
            exp_info = 8'h00;
            check("reset_strobes", {29'd0, frameValid, framingError, parityError}, 32'd0);
            check("reset_info", {24'd0, informationBits}, {24'd0, exp_info});
            check("reset_busy", {31'd0, busy}, 32'd0);
        end else begin
            if ((32'(frameValid) + 32'(framingError) + 32'(parityError)) > 1) begin
                check("strobe_exclusive", {29'd0, frameValid, framingError, parityError}, 32'd0);
            end else if (frameValid || framingError || parityError) begin
                if (q.size() == 0) begin
                    check("unexpected_strobe", {29'd0, frameValid, framingError, parityError}, 32'd0);
                end else begin
                    ev_t e;
                    int  kind;
                    e    = q.pop_front();
                    kind = frameValid ? K_VALID : (framingError ? K_FERR : K_PERR);
                    check("strobe_kind", kind, e.kind);
                    check("strobe_cycle", cyc, e.due);
                    if (e.kind == K_VALID) exp_info = e.data;
                end
            end
            check("info", {24'd0, informationBits}, {24'd0, exp_info});
        end
    end

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit par_flip,
                              input int low_hold_bits);
        ev_t e;
        e.data = d;
        e.due  = cyc + LAT;
        if (!stop_ok)                    e.kind = K_FERR;
        else if (par_flip && PBITS == 1) e.kind = K_PERR;
        else                             e.kind = K_VALID;
        q.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_FRAME_RX_PARITY_EN
        drive_bit((^d) ^ par_flip);
`endif
        drive_bit(stop_ok);
        if (!stop_ok) begin
            repeat (low_hold_bits) drive_bit(1'b0);
            rx = 1'b1;
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(name, q.size(), 0);
        q.delete();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        idle(5);

        // Reset in the middle of a frame abandons it without a strobe
        rx = 1'b0;
        repeat (CPB * 3) @(negedge clk);
        check("busy_midframe", {31'd0, busy}, 32'd1);
        #2 reset = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        idle(CPB * 2);
        check("after_reset_busy", {31'd0, busy}, 32'd0);
        check("after_reset_info", {24'd0, informationBits}, 32'h00);

        send_frame(8'hA5, 1'b1, 1'b0, 0);
        idle(4);
        drain("drain_a5");
        check("frame_a5", {24'd0, informationBits}, 32'hA5);

        send_frame(8'b01_10_0011, 1'b1, 1'b0, 0);
        idle(4);
        drain("drain_fields");
        check("field_origin", {30'd0, informationBits[7:6]}, 32'd1);
        check("field_dest", {30'd0, informationBits[5:4]}, 32'd2);
        check("field_data", {28'd0, informationBits[3:0]}, 32'd3);

        rx = 1'b0;
        repeat (5) @(negedge clk);
        idle(CPB * 2);
        check("false_start_busy", {31'd0, busy}, 32'd0);
        drain("drain_false_start");
        check("false_start_info", {24'd0, informationBits}, 32'h63);

        send_frame(8'h3C, 1'b0, 1'b0, 3);
        idle(CPB);
        drain("drain_ferr");
        check("ferr_info_kept", {24'd0, informationBits}, 32'h63);
        send_frame(8'h81, 1'b1, 1'b0, 0);
        idle(4);
        drain("drain_81");
        check("frame_81", {24'd0, informationBits}, 32'h81);

`ifdef UART_FRAME_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1, 0);
        idle(4);
        drain("drain_perr");
        check("perr_info_kept", {24'd0, informationBits}, 32'h81);
        send_frame(8'h07, 1'b1, 1'b0, 0);
        idle(4);
        drain("drain_par_ok");
        check("frame_07", {24'd0, informationBits}, 32'h07);
`endif

        for (int f = 0; f < 40; f++) begin
            logic [7:0] d;
            bit         stop_ok;
            bit         pf;
            d       = 8'($urandom);
            stop_ok = ($urandom_range(0, 4) != 0);
            pf      = (PBITS == 1) && ($urandom_range(0, 3) == 0);
            send_frame(d, stop_ok, pf, int'($urandom_range(0, 2)));
            if (!stop_ok) idle(CPB + int'($urandom_range(0, 16)));
            else          idle(int'($urandom_range(0, 12)));
            if ($urandom_range(0, 5) == 0) begin
                rx = 1'b0;
                repeat ($urandom_range(1, 5)) @(negedge clk);
                idle(CPB);
            end
        end
        idle(CPB);
        drain("drain_random");
        check("final_busy", {31'd0, busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_frame_rx.md
Name: uart_frame_rx

Overview:
Serial-to-parallel UART receive stage that turns the board's RX line into the 8-bit information frame consumed by the switch-addressed Receiver stage. The frame layout is: [7:6] origin switch ID, [5:4] destination switch ID, [3:0] data nibble. The block provides mid-bit sampling, a false-start reject, a framing check and a one-cycle valid strobe. It sits directly between the pin synchronizer and the Receiver's informationBits input.

Parameters:
CLKS_PER_BIT, 5208, clk cycles per UART bit (50 MHz / 9600 baud); must be >= 4.
DATA_BITS, 8, payload bits per frame; fixed at 8 for this system, not to be overridden.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
rx  input  1  raw serial line, idle high, asynchronous to clk
informationBits  output  8  last good frame; [7:6] origin, [5:4] destination, [3:0] data
frameValid  output  1  one-cycle pulse: informationBits just updated
framingError  output  1  one-cycle pulse: stop bit sampled low
parityError  output  1  one-cycle pulse: parity mismatch (see Optional Feature)
busy  output  1  high whenever state != IDLE

Behaviour:
- Input synchronizer:
  - rx passes through a 2-flop synchronizer (rx_s), reset to 1.
  - All decisions use rx_s; the extra 2-cycle latency is accepted.
- Reset (reset == 0, asynchronous):
  - state = IDLE, bit counter = 0, clock counter = 0.
  - informationBits = 8'h00; frameValid, framingError, parityError = 0; busy = 0.
  - Reset mid-frame abandons the frame; no strobe is issued.
- FSM states: IDLE, START, DATA, [PARITY], STOP, WAIT_HIGH.
  - IDLE: on rx_s == 0, go to START and clear the clock counter.
  - START: count CLKS_PER_BIT/2 − 1 cycles (integer division), then sample at mid-bit.
    - rx_s == 0: go to DATA, bit index = 0.
    - rx_s == 1: false start, return to IDLE, no strobe.
  - DATA: every CLKS_PER_BIT cycles, sample rx_s into the shift register, LSB first.
    - Bit 0 lands in informationBits[0], so the data nibble arrives first and the origin ID last.
    - After bit 7 is sampled, go to STOP, or to PARITY when the macro is defined.
  - STOP: after CLKS_PER_BIT cycles, sample rx_s.
    - rx_s == 1 and no parity error: load informationBits from the shift register; pulse frameValid on the next cycle; go to IDLE.
    - rx_s == 0: informationBits unchanged; pulse framingError; go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s == 1, then go to IDLE. This prevents a line break being taken as back-to-back start bits.
- Strobes:
  - frameValid, framingError and parityError are registered and high for exactly one clk.
  - They are mutually exclusive. A parity error takes priority over frameValid; a framing error takes priority over parity.
- Back-to-back frames: IDLE is re-entered at mid-stop-bit, so a start edge that immediately follows the stop bit is caught with full margin.
- Counters:
  - Clock counter width is $clog2(CLKS_PER_BIT); it saturates by reload and never wraps mid-bit.
  - Bit counter is 3 bits.
- rx glitches shorter than CLKS_PER_BIT/2 during IDLE are rejected by the START resample.

Optional Feature:
Macro: UART_FRAME_RX_PARITY_EN
- Defined:
  - One even-parity bit follows data bit 7; it is sampled in the PARITY state, CLKS_PER_BIT after bit 7.
  - Mismatch means the XOR of the 8 data bits and the parity bit is not 0.
  - On mismatch at the STOP sample: parityError pulses, informationBits is not updated, frameValid does not pulse.
- Not defined:
  - No PARITY state; the frame is 10 bits.
  - parityError is tied to 0.

Test Plan:
- Reset: hold reset = 0 mid-frame, then release → informationBits = 8'h00, all strobes 0, busy = 0, FSM in IDLE.
- Good frame, CLKS_PER_BIT = 16: send 8'hA5 LSB-first with stop = 1 → informationBits = 8'hA5 and frameValid high for exactly 1 cycle, about 9.5 bit times after the start edge.
- Fields: send 8'b01_10_0011 → informationBits[7:6] = 2'b01, [5:4] = 2'b10, [3:0] = 4'h3.
- False start: rx low for 5 clk, then high (CLKS_PER_BIT = 16) → return to IDLE; no frameValid or framingError pulse.
- Framing error: send 8'h3C with stop = 0, held low 3 bit times, then a good 8'h81 → framingError pulses once and informationBits stays at the prior value; the block waits for rx high, then receives 8'h81 with frameValid.
- Parity (macro defined): send 8'h07 with parity = 0 → parityError pulses and informationBits is unchanged; with parity = 1 → frameValid and informationBits = 8'h07.
